multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It drives the datapath mux selects, write enables and the 4-bit ALU control code into the ALU. It consumes the ALU `Zero` flag to resolve branches. It sits between the instruction register, memory handshake and register file, and owns the FETCH→DECODE→EXECUTE→WRITEBACK sequence.

## Interface
- No parameters. All encodings are fixed in the shared package.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `op  in  7`: instruction opcode, `IR[6:0]`.
- `funct3  in  3`: `IR[14:12]`.
- `funct7b5  in  1`: `IR[30]`.
- `Zero  in  1`: ALU zero flag for the current-cycle ALU operation.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `mem_req  out  1`: memory access request.
- `mem_write  out  1`: store strobe.
- `adr_src  out  1`: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write  out  1`: latch IR and OldPC.
- `pc_write  out  1`: update PC from Result.
- `reg_write  out  1`: register file write.
- `result_src  out  2`: Result select. 00 = ALUOut, 01 = Data, 10 = ALU direct.
- `alu_src_a  out  2`: ALU operand A. 00 = PC, 01 = OldPC, 10 = rs1 reg, 11 = zero.
- `alu_src_b  out  2`: ALU operand B. 00 = rs2 reg, 01 = ImmExt, 10 = constant 4.
- `imm_src  out  3`: immediate format. I = 000, S = 001, B = 010, J = 011, U = 100.
- `ALUControl  out  4`: ALU code.
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `trap  out  1`: illegal instruction detected. Sticky until reset.

## Operation
- **Moore FSM.** All outputs decode from the state, except:
  - `imm_src`, which decodes from `op`.
  - `ir_write` and `pc_write` in FETCH, which are gated by `mem_ready`.
  - `pc_write` in BRANCH, which is the taken decision.
- **RESET.** Entered while `rst_n` = 0. All outputs are 0. The first clock edge after release moves to FETCH.
- **FETCH.**
  - Drives `mem_req`=1, `adr_src`=0, A=PC, B=4, ADD, `result_src`=10.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, next state DECODE.
  - When `mem_ready`=0: all enables are 0 and the FSM stays in FETCH.
- **DECODE.** A=OldPC, B=Imm, ADD (branch/JAL target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → ILLEGAL
- **MEMADR.** A=rs1, B=Imm, ADD. Next state MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD.** `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then MEMWB.
- **MEMWB.** `result_src`=01, `reg_write`=1. Next state FETCH.
- **MEMWRITE.** `mem_req`=1, `adr_src`=1, `mem_write`=1. Holds until `mem_ready`, then FETCH.
- **EXECUTER.** A=rs1, B=rs2. ALU code = {`funct7b5`, `funct3`}. Next state ALUWB.
- **EXECUTEI.** A=rs1, B=Imm. ALU code = {`funct3`==101 ? `funct7b5` : 0, `funct3`}. Next state ALUWB.
- **ALUWB.** `result_src`=00, `reg_write`=1. Next state FETCH.
- **BRANCH.** A=rs1, B=rs2, `result_src`=00. Next state FETCH. ALU code and `pc_write` by `funct3`:
  - BEQ (000): SUB, `pc_write` = `Zero`.
  - BNE (001): SUB, `pc_write` = !`Zero`.
  - BLT (100): SLT, `pc_write` = !`Zero`.
  - BGE (101): SLT, `pc_write` = `Zero`.
  - BLTU (110): SLTU, `pc_write` = !`Zero`.
  - BGEU (111): SLTU, `pc_write` = `Zero`.
- **JAL.** A=OldPC, B=4, ADD, `result_src`=00, `pc_write`=1. Next state ALUWB, which writes the link PC+4.
- **JALR.** A=OldPC, B=4, ADD, `result_src`=10, `reg_write`=1. Next state JALRPC.
- **JALRPC.** A=rs1 (latched in DECODE, so rd==rs1 is safe), B=Imm, ADD, `result_src`=10, `pc_write`=1. Next state FETCH.
- **LUI.** A=zero, B=Imm, ADD. Next state ALUWB.
- **AUIPC.** A=OldPC, B=Imm, ADD. Next state ALUWB.
- **Illegal encodings** → ILLEGAL. These are:
  - unknown `op`;
  - R-type with `funct7b5`=1 and `funct3` ∉ {000, 101};
  - branch with `funct3` ∈ {010, 011}.
- **ILLEGAL.** `trap`=1, all enables 0. Terminal until reset.
- **Default ALU code** is ADD in every state not listed above.

## Timing
- Cycle counts with `mem_ready` held at 1:
  - R/I-ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `Zero` is sampled combinationally in BRANCH. No registered flags.
- State register is the only flop besides the sticky `trap`.
- Asserting `rst_n` mid-instruction aborts immediately: outputs go to 0 asynchronously and no partial write is issued after the assert.

## Structure
- Package `riscv_ctrl_pkg`:
  - state enum;
  - `alu_ctrl_e` with the codes above;
  - opcode localparams;
  - `result_src`, `alu_src_a`, `alu_src_b` and `imm_src` encodings.
- Sub-module `alu_decoder`: combinational; (state class, `op`, `funct3`, `funct7b5`) → `ALUControl` plus an illegal flag.

## Test plan
- **R-type SUB** (`op`=0110011, `funct3`=000, `funct7b5`=1), `mem_ready`=1:
  - states FETCH, DECODE, EXECUTER, ALUWB;
  - `ALUControl`=1000 in EXECUTER;
  - `reg_write`=1 only in cycle 4.
- **SRAI** (`op`=0010011, `funct3`=101, `funct7b5`=1) → `ALUControl`=1101. **ADDI** with `funct7b5`=1 → 0000.
- **Load** with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `reg_write` with `result_src`=01 in the last cycle.
- **Branches:**
  - BGE with `Zero`=1 → `pc_write`=1, `ALUControl`=0010.
  - BNE with `Zero`=1 → `pc_write`=0.
- **JALR** → `reg_write` in cycle 3, `pc_write` in cycle 4, never both in one cycle.
- **Traps and reset:**
  - `op`=1111111 → `trap`=1 and the FSM stays in ILLEGAL.
  - Deasserting `rst_n` mid-MEMWRITE → `mem_write` drops without waiting for a clock edge; after release the FSM is in FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control path.
// Rev 1.0
package riscv_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC,
    S_LUI, S_AUIPC, S_ILLEGAL
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_R, ALU_CLS_I, ALU_CLS_BR
  } alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] fmt;
    case (op)
      OP_STORE:          fmt = IMM_S;
      OP_BRANCH:         fmt = IMM_B;
      OP_JAL:            fmt = IMM_J;
      OP_LUI, OP_AUIPC:  fmt = IMM_U;
      default:           fmt = IMM_I;
    endcase
    return fmt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls.
// Rev 1.0
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] ALUControl;
  logic       trap;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, ALUControl, trap
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, ALUControl, trap
  );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// alu_decoder: ALU code per state class, plus illegal-encoding detection.
// Rev 1.0
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  cls_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o,
  output logic        illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      ALU_CLS_R:  alu_ctrl_o = {funct7b5_i, funct3_i};
      // Only shifts use bit 30 as an opcode bit in immediate form.
      ALU_CLS_I:  alu_ctrl_o = {(funct3_i == 3'b101) & funct7b5_i, funct3_i};
      ALU_CLS_BR: begin
        case (funct3_i[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      default:    alu_ctrl_o = ALU_ADD;
    endcase
  end

  always_comb begin
    illegal_o = 1'b0;
    case (op_i)
      OP_LOAD, OP_STORE, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_o = 1'b0;
      OP_R:      illegal_o = funct7b5_i && !(funct3_i == 3'b000 || funct3_i == 3'b101);
      OP_BRANCH: illegal_o = (funct3_i[2:1] == 2'b01);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: Moore control FSM sequencing fetch/decode/execute/writeback.
// Rev 1.0
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus
);

  state_e     state_q, state_d;
  logic       trap_q;
  alu_class_e alu_cls;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic       br_taken;

  alu_decoder u_alu_dec (
    .cls_i      (alu_cls),
    .op_i       (bus.op),
    .funct3_i   (bus.funct3),
    .funct7b5_i (bus.funct7b5),
    .alu_ctrl_o (alu_ctrl),
    .illegal_o  (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_q | (state_d == S_ILLEGAL);
    end
  end

  // Zero means "equal" after SUB and "not less" after SLT/SLTU.
  always_comb begin
    case (bus.funct3)
      3'b000, 3'b101, 3'b111: br_taken = bus.Zero;
      default:                br_taken = !bus.Zero;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    alu_cls        = ALU_CLS_ADD;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        if (illegal) state_d = S_ILLEGAL;
        else begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECUTER;
            OP_IMM:            state_d = S_EXECUTEI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_AUIPC;
            default:           state_d = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_DATA;
        bus.reg_write  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        bus.alu_src_a = SRCA_RS1;
        alu_cls = ALU_CLS_R;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        alu_cls = ALU_CLS_I;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = SRCA_RS1;
        bus.pc_write  = br_taken;
        alu_cls = ALU_CLS_BR;
        state_d = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        bus.alu_src_a  = SRCA_OLDPC;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        bus.reg_write  = 1'b1;
        state_d = S_JALRPC;
      end
      S_JALRPC: begin
        bus.alu_src_a  = SRCA_RS1;
        bus.alu_src_b  = SRCB_IMM;
        bus.result_src = RES_ALU;
        bus.pc_write   = 1'b1;
        state_d = S_FETCH;
      end
      S_LUI: begin
        bus.alu_src_a = SRCA_ZERO;
        bus.alu_src_b = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_RESET;
    endcase
  end

  assign bus.ALUControl = alu_ctrl;
  assign bus.imm_src    = (state_q == S_RESET) ? IMM_I : imm_src_of(bus.op);
  assign bus.trap       = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: directed and random instructions checked against an
// instruction-level model of the control sequence.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       req, wr, adr, irw, pcw, rgw;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       trap;
  } ov_t;

  typedef enum int {K_PLAIN, K_FETCH, K_MEM, K_BR} kind_e;
  typedef struct {
    kind_e kind;
    ov_t   ov;
  } phase_t;

  phase_t plan[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ov_t obs_vec();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
            bus.ALUControl, bus.imm_src, bus.trap};
  endfunction

  function automatic ov_t mk(input logic req, input logic wr, input logic adr,
                             input logic pcw, input logic rgw, input logic [1:0] rs,
                             input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu);
    ov_t v;
    v = '0;
    v.req = req; v.wr = wr; v.adr = adr; v.pcw = pcw; v.rgw = rgw;
    v.rs = rs; v.a = a; v.b = b; v.alu = alu;
    return v;
  endfunction

  function automatic logic [2:0] imm_fmt(input logic [6:0] o);
    case (o)
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h6F:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (o)
      7'h03, 7'h23, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
      7'h33: return !f7 || f3 == 3'd0 || f3 == 3'd5;
      7'h63: return !(f3 == 3'd2 || f3 == 3'd3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] br_alu(input logic [2:0] f3);
    if (f3 < 3'd2) return 4'b1000;
    if (f3 < 3'd6) return 4'b0010;
    return 4'b0011;
  endfunction

  // Zero: equal for BEQ/BNE, "not less" for the ordered compares.
  function automatic logic taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0:       return z;
      3'd1:       return !z;
      3'd4, 3'd6: return !z;
      default:    return z;
    endcase
  endfunction

  task automatic add(input kind_e k, input ov_t v);
    phase_t p;
    p.kind = k;
    p.ov = v;
    plan.push_back(p);
  endtask

  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    ov_t wb;
    wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0);
    plan.delete();
    add(K_FETCH, mk(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0));
    add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0));
    if (legal(o, f3, f7)) begin
      case (o)
        7'h03: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0));
          add(K_MEM,   mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0));
          add(K_PLAIN, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'h0));
        end
        7'h23: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0));
          add(K_MEM,   mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0));
        end
        7'h33: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, {f7, f3}));
          add(K_PLAIN, wb);
        end
        7'h13: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, {(f3 == 3'd5) && f7, f3}));
          add(K_PLAIN, wb);
        end
        7'h63: add(K_BR, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, br_alu(f3)));
        7'h6F: begin
          add(K_PLAIN, mk(0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 4'h0));
          add(K_PLAIN, wb);
        end
        7'h67: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 4'h0));
          add(K_PLAIN, mk(0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 4'h0));
        end
        7'h37: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'h0));
          add(K_PLAIN, wb);
        end
        default: begin
          add(K_PLAIN, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0));
          add(K_PLAIN, wb);
        end
      endcase
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk($sformatf("%s reset", nm), obs_vec(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // fst/mst: forced stall count in FETCH / memory states (-1 = random);
  // zm: Zero value (-1 = random); abort: pull reset while in the memory state.
  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int fst, input int mst, input int zm,
                           input bit abort, output int cyc);
    ov_t e;
    bit  ok;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    build(o, f3, f7);
    ok = legal(o, f3, f7);
    cyc = 0;
    for (int i = 0; i < plan.size(); i++) begin
      int  stalls = 0;
      int  limit  = (plan[i].kind == K_FETCH) ? fst : mst;
      bit  waits  = (plan[i].kind == K_FETCH) || (plan[i].kind == K_MEM);
      bit  adv    = 1'b0;
      while (!adv) begin
        @(negedge clk);
        if (waits) begin
          if (limit < 0) bus.mem_ready = (stalls >= 4) || ($urandom_range(0, 99) < 70);
          else           bus.mem_ready = (stalls >= limit);
        end else begin
          bus.mem_ready = 1'($urandom_range(0, 1));
        end
        bus.Zero = (zm < 0) ? 1'($urandom_range(0, 1)) : zm[0];
        #1;
        e = plan[i].ov;
        e.imm = imm_fmt(o);
        if (plan[i].kind == K_FETCH) begin
          e.irw = bus.mem_ready;
          e.pcw = bus.mem_ready;
        end
        if (plan[i].kind == K_BR) e.pcw = taken(f3, bus.Zero);
        chk($sformatf("%s cyc%0d", nm, cyc + 1), obs_vec(), e);
        cyc++;
        if (abort && plan[i].kind == K_MEM) begin
          #2 rst_n = 1'b0;
          #1 chk($sformatf("%s abort mem_write", nm), bus.mem_write, 32'h0);
          chk($sformatf("%s abort outputs", nm), obs_vec(), 32'h0);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        adv = !waits || bus.mem_ready;
        if (!adv) stalls++;
      end
    end
    if (!ok) begin
      repeat (3) begin
        @(negedge clk);
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.Zero = 1'($urandom_range(0, 1));
        #1;
        e = '0;
        e.imm = imm_fmt(o);
        e.trap = 1'b1;
        chk($sformatf("%s illegal", nm), obs_vec(), e);
      end
      do_reset(nm);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [9];
    int cyc;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    bus.op = 7'h0;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    #2 chk("reset state", obs_vec(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("sub", 7'h33, 3'd0, 1'b1, 0, 0, -1, 1'b0, cyc);
    chk("sub cycles", cyc, 4);
    run_instr("srai", 7'h13, 3'd5, 1'b1, 0, 0, -1, 1'b0, cyc);
    run_instr("addi_f7", 7'h13, 3'd0, 1'b1, 0, 0, -1, 1'b0, cyc);
    run_instr("load_stall", 7'h03, 3'd2, 1'b0, 0, 2, -1, 1'b0, cyc);
    chk("load cycles", cyc, 7);
    run_instr("store", 7'h23, 3'd2, 1'b0, 0, 0, -1, 1'b0, cyc);
    chk("store cycles", cyc, 4);
    run_instr("bge_z1", 7'h63, 3'd5, 1'b0, 0, 0, 1, 1'b0, cyc);
    chk("branch cycles", cyc, 3);
    run_instr("bne_z1", 7'h63, 3'd1, 1'b0, 0, 0, 1, 1'b0, cyc);
    run_instr("jalr", 7'h67, 3'd0, 1'b0, 0, 0, -1, 1'b0, cyc);
    run_instr("jal", 7'h6F, 3'd0, 1'b0, 2, 0, -1, 1'b0, cyc);
    chk("jal fetch-stall cycles", cyc, 6);
    run_instr("illegal_op", 7'h7F, 3'd0, 1'b0, 0, 0, -1, 1'b0, cyc);
    run_instr("store_abort", 7'h23, 3'd0, 1'b0, 0, 3, -1, 1'b1, cyc);
    run_instr("after_abort", 7'h37, 3'd0, 1'b0, 0, 0, -1, 1'b0, cyc);

    for (int n = 0; n < 160; n++) begin
      int r;
      logic [6:0] o;
      r = $urandom_range(0, 9);
      o = (r < 9) ? ops[r] : 7'($urandom);
      run_instr($sformatf("rnd%0d op%h", n, o), o, 3'($urandom), 1'($urandom),
                -1, -1, -1, 1'b0, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
